// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Holds FSM state encodings, owner encodings and small helpers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_REQ  = 2'b01,
        ARB_RESP = 2'b10
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam int STARVE_W = 4;
    localparam int TMO_W    = 8;

    function automatic logic [STARVE_W-1:0] sat_inc(
        input logic [STARVE_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_grant_sel.sv
// arb_grant_sel: data-priority owner select with a fetch starvation guard.
// Ports: clk, rst, i_valid_in, d_valid_in, grant_stb_in -> owner_out, grant_valid_out.
module arb_grant_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid_in,
    input  logic d_valid_in,
    input  logic grant_stb_in,
    output logic owner_out,
    output logic grant_valid_out
);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                force_i;

    // Fetch is forced only once data has won STARVE_MAX times back to back.
    assign force_i         = i_valid_in && (starve_cnt_q == STARVE_W'(STARVE_MAX));
    assign grant_valid_out = i_valid_in | d_valid_in;
    assign owner_out       = (d_valid_in && !force_i) ? OWNER_D : OWNER_I;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_stb_in) begin
            if (owner_out == OWNER_I) begin
                starve_cnt_d = '0;
            end else if (i_valid_in) begin
                starve_cnt_d = sat_inc(starve_cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (i_*) and data (d_*) requesters.
// Ports: fetch req/resp, data req/resp, mem_* downstream, busy_out, timeout_err_out.
// Optional response timeout enabled by defining ARB_RESP_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid_in,
    input  logic [ADDR_W-1:0]   i_req_addr_in,
    output logic                i_req_ready_out,
    output logic                i_resp_valid_out,
    output logic [DATA_W-1:0]   i_resp_rdata_out,
    input  logic                d_req_valid_in,
    input  logic [ADDR_W-1:0]   d_req_addr_in,
    input  logic                d_req_wen_in,
    input  logic [DATA_W-1:0]   d_req_wdata_in,
    input  logic [DATA_W/8-1:0] d_req_byte_en_in,
    output logic                d_req_ready_out,
    output logic                d_resp_valid_out,
    output logic [DATA_W-1:0]   d_resp_rdata_out,
    output logic                mem_valid_out,
    output logic [ADDR_W-1:0]   mem_addr_out,
    output logic                mem_wen_out,
    output logic [DATA_W-1:0]   mem_wdata_out,
    output logic [DATA_W/8-1:0] mem_byte_en_out,
    input  logic                mem_ready_in,
    input  logic                mem_rvalid_in,
    input  logic [DATA_W-1:0]   mem_rdata_in,
    output logic                busy_out,
    output logic                timeout_err_out
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              i_rv_q, i_rv_d;
    logic              d_rv_q, d_rv_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              gnt_owner, gnt_valid, grant_stb;

`ifdef ARB_RESP_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;
`endif

    assign grant_stb = (state_q == ARB_IDLE) && gnt_valid;

    arb_grant_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant_sel (
        .clk             (clk),
        .rst             (rst),
        .i_valid_in      (i_req_valid_in),
        .d_valid_in      (d_req_valid_in),
        .grant_stb_in    (grant_stb),
        .owner_out       (gnt_owner),
        .grant_valid_out (gnt_valid)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_valid_d = mem_valid_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        i_rv_d      = 1'b0;
        d_rv_d      = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    owner_d     = gnt_owner;
                    mem_valid_d = 1'b1;
                    state_d     = ARB_REQ;
                    if (gnt_owner == OWNER_D) begin
                        addr_d    = d_req_addr_in;
                        wen_d     = d_req_wen_in;
                        wdata_d   = d_req_wdata_in;
                        be_d      = d_req_byte_en_in;
                        d_ready_d = 1'b1;
                    end else begin
                        addr_d    = i_req_addr_in;
                        wen_d     = 1'b0;
                        wdata_d   = '0;
                        be_d      = '1;
                        i_ready_d = 1'b1;
                    end
                end
            end
            ARB_REQ: begin
                if (mem_ready_in) begin
                    mem_valid_d = 1'b0;
                    state_d     = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (mem_rvalid_in) begin
                    state_d = ARB_IDLE;
                    if (owner_q == OWNER_D) begin
                        d_rv_d    = 1'b1;
                        d_rdata_d = mem_rdata_in;
                    end else begin
                        i_rv_d    = 1'b1;
                        i_rdata_d = mem_rdata_in;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

`ifdef ARB_RESP_TIMEOUT_EN
        tmo_err_d = 1'b0;
        tmo_cnt_d = (state_q == ARB_IDLE) ? '0 : tmo_cnt_q + 1'b1;
        // A real response in the same cycle as expiry takes precedence.
        if (state_q != ARB_IDLE && state_d != ARB_IDLE
            && tmo_cnt_q == TMO_LAST) begin
            state_d     = ARB_IDLE;
            mem_valid_d = 1'b0;
            tmo_err_d   = 1'b1;
            if (owner_q == OWNER_D) begin
                d_rv_d    = 1'b1;
                d_rdata_d = '0;
            end else begin
                i_rv_d    = 1'b1;
                i_rdata_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWNER_I;
            mem_valid_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rv_q      <= 1'b0;
            d_rv_q      <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_valid_q <= mem_valid_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_rv_q      <= i_rv_d;
            d_rv_q      <= d_rv_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

`ifdef ARB_RESP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end
    assign timeout_err_out = tmo_err_q;
`else
    assign timeout_err_out = 1'b0;
`endif

    assign i_req_ready_out  = i_ready_q;
    assign i_resp_valid_out = i_rv_q;
    assign i_resp_rdata_out = i_rdata_q;
    assign d_req_ready_out  = d_ready_q;
    assign d_resp_valid_out = d_rv_q;
    assign d_resp_rdata_out = d_rdata_q;
    assign mem_valid_out    = mem_valid_q;
    assign mem_addr_out     = addr_q;
    assign mem_wen_out      = wen_q;
    assign mem_wdata_out    = wdata_q;
    assign mem_byte_en_out  = be_q;
    assign busy_out         = (state_q != ARB_IDLE);

endmodule
